// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, write-back source and write-back FSM encodings
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int RADDR_W = 4;
    localparam logic [3:0] R_ZERO = 4'd0;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_DMEM = 2'd1, WB_PC1 = 2'd2} wb_src_e;
    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WAIT_LOAD, S_HALTED} wb_fsm_e;
endpackage

// File: rtl/wb_stage.sv
// wb_stage: write-back register, source mux, forwarding, load stall/timeout, retire/halt
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RADDR_W = cpu_pkg::RADDR_W,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               mem_rf_we,
    input  logic [RADDR_W-1:0] mem_dst,
    input  logic [1:0]         mem_src,
    input  logic [DATA_W-1:0]  mem_alu,
    input  logic [DATA_W-1:0]  mem_pc1,
    input  logic               mem_halt,
    input  logic               flush,
    input  logic [DATA_W-1:0]  dm_rdata,
    input  logic               dm_rvalid,
    output logic [RADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               rf_we,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               wb_stall,
    output logic               halted,
    output logic               err_timeout,
    output logic [15:0]        instret
);
    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    wb_fsm_e state, state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic wb_valid, wb_rf_we, wb_halt;
    logic [RADDR_W-1:0] wb_dst;
    logic [1:0] wb_src;
    logic [DATA_W-1:0] wb_alu, wb_pc1;
    logic is_load, data_ready, timeout_now, retire, halt_now;
    always_comb begin
        halted = state == S_HALTED;
        is_load = wb_valid && wb_src == WB_DMEM;
        data_ready = !is_load || dm_rvalid;
        timeout_now = is_load && !dm_rvalid && wait_cnt == CNT_W'(LOAD_TIMEOUT);
        retire = wb_valid && !halted && (data_ready || timeout_now);
        halt_now = retire && wb_halt;
        wb_stall = (is_load && !dm_rvalid && !timeout_now) || halted;
        rf_w_addr = wb_dst;
        rf_wdata = wb_src == WB_DMEM ? dm_rdata : wb_src == WB_PC1 ? wb_pc1 : wb_alu;
        fwd_valid = wb_valid && wb_rf_we && wb_dst != RADDR_W'(R_ZERO) && data_ready;
        fwd_addr = rf_w_addr;
        fwd_data = rf_wdata;
        rf_we = retire && fwd_valid;
        state_nx = (halted || halt_now) ? S_HALTED : wb_stall ? S_WAIT_LOAD :
                   (mem_valid && !flush) ? S_ACTIVE : S_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            wait_cnt <= '0;
            err_timeout <= 1'b0;
            instret <= '0;
            wb_valid <= 1'b0;
            wb_rf_we <= 1'b0;
            wb_halt <= 1'b0;
            wb_dst <= '0;
            wb_src <= WB_ALU;
            wb_alu <= '0;
            wb_pc1 <= '0;
        end else begin
            state <= state_nx;
            wait_cnt <= (wb_stall && !halted) ? wait_cnt + 1'b1 : '0;
            err_timeout <= err_timeout || timeout_now;
            instret <= instret + 16'(retire);
            // the HLT's own retire edge must not let a younger instruction in
            if (!wb_stall) begin
                wb_valid <= mem_valid && !flush && !halt_now;
                wb_rf_we <= mem_rf_we;
                wb_halt <= mem_halt;
                wb_dst <= mem_dst;
                wb_src <= mem_src;
                wb_alu <= mem_alu;
                wb_pc1 <= mem_pc1;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus with a queue scoreboard of expected register writes
module tb_wb_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic mem_valid = 1'b0, mem_rf_we = 1'b0, mem_halt = 1'b0, flush = 1'b0, dm_rvalid = 1'b0;
    logic [3:0] mem_dst = '0;
    logic [1:0] mem_src = '0;
    logic [15:0] mem_alu = '0, mem_pc1 = '0, dm_rdata = '0;
    logic [3:0] rf_w_addr, fwd_addr;
    logic [15:0] rf_wdata, fwd_data, instret;
    logic rf_we, fwd_valid, wb_stall, halted, err_timeout;
    int checks = 0, failures = 0;
    typedef struct {logic [3:0] a; logic [15:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t w;

    wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_rf_we(mem_rf_we), .mem_dst(mem_dst),
        .mem_src(mem_src), .mem_alu(mem_alu), .mem_pc1(mem_pc1), .mem_halt(mem_halt), .flush(flush),
        .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid), .rf_w_addr(rf_w_addr), .rf_wdata(rf_wdata),
        .rf_we(rf_we), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_stall(wb_stall), .halted(halted), .err_timeout(err_timeout), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem(input logic v, input logic we, input logic [3:0] dst, input logic [1:0] src,
                       input logic [15:0] alu, input logic [15:0] pc1, input logic hlt, input logic fl);
        mem_valid = v; mem_rf_we = we; mem_dst = dst; mem_src = src;
        mem_alu = alu; mem_pc1 = pc1; mem_halt = hlt; flush = fl;
    endtask

    task automatic idle();
        mem(1'b0, 1'b0, 4'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // every register-file write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected none", rf_w_addr, rf_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(rf_w_addr), 32'(w.a));
                chk("wr_data", 32'(rf_wdata), 32'(w.d));
            end
        end
    end

    initial begin
        #3;
        chk("rst_outputs", {rf_we, fwd_valid, wb_stall, halted, err_timeout, rf_w_addr, rf_wdata}, 0);
        chk("rst_instret", 32'(instret), 0);
        @(negedge clk); rst = 1'b0;
        tick();
        // ALU write
        mem(1'b1, 1'b1, 4'd3, 2'd0, 16'h1234, 16'h0, 1'b0, 1'b0); push(4'd3, 16'h1234);
        tick(); idle();
        chk("alu_we", 32'(rf_we), 1);
        chk("alu_addr", 32'(rf_w_addr), 3);
        chk("alu_data", 32'(rf_wdata), 32'h1234);
        chk("alu_fwd", {fwd_valid, fwd_addr, fwd_data}, {1'b1, 4'd3, 16'h1234});
        tick();
        chk("alu_instret", 32'(instret), 1);
        chk("alu_we_after", 32'(rf_we), 0);
        // R0 suppression
        mem(1'b1, 1'b1, 4'd0, 2'd0, 16'hFFFF, 16'h0, 1'b0, 1'b0);
        tick(); idle();
        chk("r0_we", 32'(rf_we), 0);
        chk("r0_fwd", 32'(fwd_valid), 0);
        tick();
        chk("r0_instret", 32'(instret), 2);
        // load with three wait cycles
        mem(1'b1, 1'b1, 4'd5, 2'd1, 16'h0, 16'h0, 1'b0, 1'b0); push(4'd5, 16'hBEEF);
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall", 32'(wb_stall), 1);
            chk("ld_fwd_wait", 32'(fwd_valid), 0);
            tick();
        end
        dm_rvalid = 1'b1; dm_rdata = 16'hBEEF; #1;
        chk("ld_stall_drop", 32'(wb_stall), 0);
        chk("ld_we", 32'(rf_we), 1);
        chk("ld_data", 32'(rf_wdata), 32'hBEEF);
        tick(); dm_rvalid = 1'b0; dm_rdata = 16'h0;
        chk("ld_err", 32'(err_timeout), 0);
        chk("ld_instret", 32'(instret), 3);
        // load timeout
        mem(1'b1, 1'b1, 4'd6, 2'd1, 16'h0, 16'h0, 1'b0, 1'b0);
        tick(); idle();
        for (int i = 0; i < 15; i++) begin
            chk("to_stall", 32'(wb_stall), 1);
            chk("to_err_early", 32'(err_timeout), 0);
            tick();
        end
        chk("to_stall_drop", 32'(wb_stall), 0);
        chk("to_we", 32'(rf_we), 0);
        mem(1'b1, 1'b1, 4'd7, 2'd0, 16'h0777, 16'h0, 1'b0, 1'b0); push(4'd7, 16'h0777);
        tick(); idle();
        chk("to_err", 32'(err_timeout), 1);
        chk("to_instret", 32'(instret), 4);
        chk("to_next_we", 32'(rf_we), 1);
        tick();
        chk("to_next_instret", 32'(instret), 5);
        chk("to_err_sticky", 32'(err_timeout), 1);
        // flush
        mem(1'b1, 1'b1, 4'd8, 2'd0, 16'h0888, 16'h0, 1'b0, 1'b1);
        tick(); idle();
        chk("fl_we", 32'(rf_we), 0);
        tick();
        chk("fl_instret", 32'(instret), 5);
        // JAL link
        mem(1'b1, 1'b1, 4'd14, 2'd2, 16'h1111, 16'h0042, 1'b0, 1'b0); push(4'd14, 16'h0042);
        tick(); idle();
        chk("jal_we", 32'(rf_we), 1);
        chk("jal_data", 32'(rf_wdata), 32'h0042);
        tick();
        chk("jal_instret", 32'(instret), 6);
        // halt; a younger valid op keeps being offered and must never write
        mem(1'b1, 1'b0, 4'd0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        mem(1'b1, 1'b1, 4'd9, 2'd0, 16'h0999, 16'h0, 1'b0, 1'b0);
        chk("hlt_not_yet", 32'(halted), 0);
        tick();
        chk("hlt_halted", 32'(halted), 1);
        chk("hlt_instret", 32'(instret), 7);
        for (int i = 0; i < 3; i++) begin
            chk("hlt_stall", 32'(wb_stall), 1);
            chk("hlt_we", 32'(rf_we), 0);
            tick();
        end
        chk("hlt_instret_hold", 32'(instret), 7);
        idle();
        // reset out of HALTED, then reset in the middle of a load wait
        rst = 1'b1; #1;
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_instret", 32'(instret), 0);
        @(negedge clk); rst = 1'b0;
        tick();
        mem(1'b1, 1'b1, 4'd5, 2'd1, 16'h0, 16'h0, 1'b0, 1'b0);
        tick(); idle();
        tick();
        chk("rw_stall", 32'(wb_stall), 1);
        #2 rst = 1'b1; #1;
        chk("rw_outputs", {rf_we, fwd_valid, wb_stall, halted, err_timeout, rf_w_addr, rf_wdata}, 0);
        chk("rw_instret", 32'(instret), 0);
        @(negedge clk); rst = 1'b0; dm_rvalid = 1'b1; dm_rdata = 16'hABCD; #1;
        chk("rw_late_we", 32'(rf_we), 0);
        tick();
        chk("rw_late_we2", 32'(rf_we), 0);
        chk("rw_late_instret", 32'(instret), 0);
        dm_rvalid = 1'b0;
        tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
